// File: rtl/fe_bf4_ld.sv
// fe_bf4_ld: ping-pong frame buffer that reorders NPT complex samples into radix-4 input groups.
// Optional `FE_BF4_LD_SOF_EN: i_valid & i_sof restarts the current write frame at address 0.
module fe_bf4_ld_lane #(
  parameter int NBW_IN = 9
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic signed [1:0][NBW_IN-1:0]   d,
  output logic signed [1:0][NBW_IN-1:0]   q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)     q <= '0;
    else if (en) q <= d;
endmodule

module fe_bf4_ld #(
  parameter int NBW_IN = 9,
  parameter int NPT    = 16
) (
  input  logic                                clk,
  input  logic                                rst_async,
  input  logic                                i_valid,
  input  logic                                i_sof,
  input  logic signed [1:0][NBW_IN-1:0]       i_data,
  output logic                                o_valid,
  output logic                                o_sof,
  output logic signed [3:0][1:0][NBW_IN-1:0]  o_data,
  output logic                                o_err
);
  localparam int Q  = NPT / 4;
  localparam int AW = $clog2(NPT);
  localparam int RW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic {IDLE, READ} state_t;

  state_t                          state;
  logic [AW-1:0]                   wcnt, waddr;
  logic [RW-1:0]                   rcnt;
  logic                            wptr, rptr;
  logic [1:0]                      full;
  logic                            wr_sof, wr_last, rd_fire, rd_last;
  logic [3:0][AW-1:0]              raddr;
  logic signed [3:0][1:0][NBW_IN-1:0] lane_d;
  logic signed [1:0][NBW_IN-1:0]   mem [2][NPT];

`ifdef FE_BF4_LD_SOF_EN
  assign wr_sof = i_valid & i_sof;
`else
  logic unused_sof;
  assign unused_sof = i_sof;
  assign wr_sof     = 1'b0;
`endif

  assign waddr   = wr_sof ? '0 : wcnt;
  assign wr_last = i_valid && (waddr == AW'(NPT-1));
  // IDLE fires group 0 on the same edge it leaves, so group 0 lands one edge after the last write
  assign rd_fire = (state == READ) || (|full);
  assign rd_last = rd_fire && (rcnt == RW'(Q-1));

  // Sample memory is deliberately not reset; wcnt/full gate what is ever read.
  always_ff @(posedge clk)
    if (i_valid) mem[wptr][waddr] <= i_data;

  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      wcnt <= '0;
      wptr <= 1'b0;
    end else if (i_valid) begin
      wcnt <= wr_last ? '0 : waddr + AW'(1);
      if (wr_last) wptr <= ~wptr;
    end

  always_ff @(posedge clk or posedge rst_async)
    if (rst_async) begin
      state   <= IDLE;
      rcnt    <= '0;
      rptr    <= 1'b0;
      full    <= '0;
      o_valid <= 1'b0;
      o_sof   <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      if (wr_last) full[wptr] <= 1'b1;
      if (rd_last) full[rptr] <= 1'b0;
      o_valid <= rd_fire;
      o_sof   <= rd_fire && (rcnt == '0);
      o_err   <= wr_sof && (wcnt != '0);
      case (state)
        IDLE: if (|full) begin
          state <= READ;
          rcnt  <= RW'(1);
        end
        READ: if (rcnt == RW'(Q-1)) begin
          rcnt <= '0;
          rptr <= ~rptr;
          if (!full[~rptr]) state <= IDLE;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
        default: state <= IDLE;
      endcase
    end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign raddr[k]  = AW'(rcnt) + AW'(k*Q);
    assign lane_d[k] = mem[rptr][raddr[k]];
    fe_bf4_ld_lane #(.NBW_IN(NBW_IN)) u_lane (
      .clk (clk),
      .rst (rst_async),
      .en  (rd_fire),
      .d   (lane_d[k]),
      .q   (o_data[k])
    );
  end
endmodule
